// File: rtl/ula_seq.sv
// Sequential command initiator for the p_ula ALU: registers operands, captures the ALU result and drives ACC.
// Define ULA_SEQ_STATS_EN to add the saturating Op_count/Carry_count statistics outputs.
module ula_seq #(
    parameter int               WIDTH    = 6,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Cmd_valid,
    output logic             Cmd_ready,
    input  logic             Cmd_Modo,
    input  logic [2:0]       Cmd_Operacao,
    input  logic [WIDTH-1:0] Cmd_Operando,
    input  logic             Cmd_Fonte,
    input  logic             Cmd_Grava,
    input  logic             Acc_clr,
    output logic [WIDTH-1:0] ula_A,
    output logic [WIDTH-1:0] ula_B,
    output logic             ula_Modo,
    output logic [2:0]       ula_Operacao,
    output logic             ula_Reset,
    input  logic [WIDTH-1:0] ula_O,
    input  logic             ula_Carry_out,
    input  logic             ula_Zero,
    output logic             Rsp_valid,
    input  logic             Rsp_ready,
    output logic [WIDTH-1:0] Rsp_O,
    output logic             Rsp_Carry,
    output logic             Rsp_Zero,
    output logic [WIDTH-1:0] Acc
`ifdef ULA_SEQ_STATS_EN
    ,
    output logic [15:0]      Op_count,
    output logic [15:0]      Carry_count
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             modo_q, modo_d;
    logic [2:0]       op_q, op_d;
    logic             grava_q, grava_d;
    logic [WIDTH-1:0] rspO_q, rspO_d;
    logic             rspC_q, rspC_d;
    logic             rspZ_q, rspZ_d;
    logic             cmdHs;
    logic             rspHs;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            acc_q   <= ACC_INIT;
            a_q     <= '0;
            b_q     <= '0;
            modo_q  <= 1'b0;
            op_q    <= 3'b000;
            grava_q <= 1'b0;
            rspO_q  <= '0;
            rspC_q  <= 1'b0;
            rspZ_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            modo_q  <= modo_d;
            op_q    <= op_d;
            grava_q <= grava_d;
            rspO_q  <= rspO_d;
            rspC_q  <= rspC_d;
            rspZ_q  <= rspZ_d;
        end
    end

    assign cmdHs = Cmd_valid && (state_q == IDLE);
    assign rspHs = (state_q == RESP) && Rsp_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        modo_d  = modo_q;
        op_d    = op_q;
        grava_d = grava_q;
        rspO_d  = rspO_q;
        rspC_d  = rspC_q;
        rspZ_d  = rspZ_q;
        case (state_q)
            IDLE: begin
                if (cmdHs) begin
                    modo_d  = Cmd_Modo;
                    op_d    = Cmd_Operacao;
                    grava_d = Cmd_Grava;
                    a_d     = Cmd_Fonte ? Cmd_Operando : acc_q;
                    b_d     = Cmd_Fonte ? acc_q : Cmd_Operando;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                rspO_d  = ula_O;
                rspC_d  = ula_Carry_out;
                rspZ_d  = ula_Zero;
                if (grava_q) begin
                    acc_d = ula_O;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rspHs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A clear overrides any result write landing on the same edge.
        if (Acc_clr) begin
            acc_d = ACC_INIT;
        end
    end

    assign Cmd_ready    = Reset_n && (state_q == IDLE);
    assign ula_Reset    = (state_q != ISSUE);
    assign Rsp_valid    = (state_q == RESP);
    assign ula_A        = a_q;
    assign ula_B        = b_q;
    assign ula_Modo     = modo_q;
    assign ula_Operacao = op_q;
    assign Rsp_O        = rspO_q;
    assign Rsp_Carry    = rspC_q;
    assign Rsp_Zero     = rspZ_q;
    assign Acc          = acc_q;

`ifdef ULA_SEQ_STATS_EN
    logic [15:0] opCnt_q, carryCnt_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            opCnt_q    <= 16'h0000;
            carryCnt_q <= 16'h0000;
        end else if (rspHs) begin
            if (opCnt_q != 16'hFFFF) begin
                opCnt_q <= opCnt_q + 16'h0001;
            end
            if (rspC_q && (carryCnt_q != 16'hFFFF)) begin
                carryCnt_q <= carryCnt_q + 16'h0001;
            end
        end
    end

    assign Op_count    = opCnt_q;
    assign Carry_count = carryCnt_q;
`endif

endmodule

// File: tb/tb_ula_seq.sv
// Directed scoreboard bench for ula_seq with a behavioural p_ula model driving the ALU result ports.
module tb_ula_seq;

    localparam int WIDTH = 6;
    localparam logic [WIDTH-1:0] ACC_INIT = '0;

    logic             Clk;
    logic             Reset_n;
    logic             Cmd_valid;
    logic             Cmd_ready;
    logic             Cmd_Modo;
    logic [2:0]       Cmd_Operacao;
    logic [WIDTH-1:0] Cmd_Operando;
    logic             Cmd_Fonte;
    logic             Cmd_Grava;
    logic             Acc_clr;
    logic [WIDTH-1:0] ula_A;
    logic [WIDTH-1:0] ula_B;
    logic             ula_Modo;
    logic [2:0]       ula_Operacao;
    logic             ula_Reset;
    logic [WIDTH-1:0] ula_O;
    logic             ula_Carry_out;
    logic             ula_Zero;
    logic             Rsp_valid;
    logic             Rsp_ready;
    logic [WIDTH-1:0] Rsp_O;
    logic             Rsp_Carry;
    logic             Rsp_Zero;
    logic [WIDTH-1:0] Acc;
`ifdef ULA_SEQ_STATS_EN
    logic [15:0]      Op_count;
    logic [15:0]      Carry_count;
`endif

    typedef struct {
        logic [WIDTH-1:0] o;
        logic             c;
        logic             z;
    } rsp_t;

    rsp_t             sbQ[$];
    logic [WIDTH-1:0] accModel;
    int               nChecks = 0;
    int               nFails  = 0;

    ula_seq #(.WIDTH(WIDTH), .ACC_INIT(ACC_INIT)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .Cmd_valid(Cmd_valid), .Cmd_ready(Cmd_ready),
        .Cmd_Modo(Cmd_Modo), .Cmd_Operacao(Cmd_Operacao),
        .Cmd_Operando(Cmd_Operando), .Cmd_Fonte(Cmd_Fonte),
        .Cmd_Grava(Cmd_Grava), .Acc_clr(Acc_clr),
        .ula_A(ula_A), .ula_B(ula_B), .ula_Modo(ula_Modo),
        .ula_Operacao(ula_Operacao), .ula_Reset(ula_Reset),
        .ula_O(ula_O), .ula_Carry_out(ula_Carry_out), .ula_Zero(ula_Zero),
        .Rsp_valid(Rsp_valid), .Rsp_ready(Rsp_ready),
        .Rsp_O(Rsp_O), .Rsp_Carry(Rsp_Carry), .Rsp_Zero(Rsp_Zero),
        .Acc(Acc)
`ifdef ULA_SEQ_STATS_EN
        , .Op_count(Op_count), .Carry_count(Carry_count)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural p_ula: returns {carry, result}; outputs are forced to zero while in reset.
    function automatic logic [WIDTH:0] aluRef(input logic rst, input logic modo,
                                              input logic [2:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        logic [WIDTH:0] r;
        r = '0;
        if (!rst) begin
            if (!modo) begin
                case (op)
                    3'b000:  r = {1'b0, a} + {1'b0, b};
                    3'b001:  r = {(a < b), a - b};
                    3'b010:  r = {1'b0, a} + 1;
                    default: r = '0;
                endcase
            end else begin
                case (op)
                    3'b000:  r = {1'b0, a & b};
                    3'b001:  r = {1'b0, ~a};
                    3'b010:  r = {1'b0, a | b};
                    3'b011:  r = {1'b0, a ^ b};
                    default: r = '0;
                endcase
            end
        end
        return r;
    endfunction

    always_comb begin
        logic [WIDTH:0] r;
        r             = aluRef(ula_Reset, ula_Modo, ula_Operacao, ula_A, ula_B);
        ula_O         = r[WIDTH-1:0];
        ula_Carry_out = r[WIDTH];
        ula_Zero      = (r[WIDTH-1:0] == '0);
    end

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nChecks++;
        assert (obs === exp)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one command; clrHs asserts Acc_clr on the handshake edge, clrCap on the capture edge.
    task automatic applyStimulus(input logic modo, input logic [2:0] op,
                                 input logic [WIDTH-1:0] operand, input logic fonte,
                                 input logic grava, input logic clrHs, input logic clrCap);
        logic [WIDTH-1:0] expA, expB;
        logic [WIDTH:0]   r;
        rsp_t             e;
        @(negedge Clk);
        Cmd_valid    = 1'b1;
        Cmd_Modo     = modo;
        Cmd_Operacao = op;
        Cmd_Operando = operand;
        Cmd_Fonte    = fonte;
        Cmd_Grava    = grava;
        Acc_clr      = clrHs;
        checkOutput("cmd_ready_idle", {15'b0, Cmd_ready}, 16'd1);
        expA = fonte ? operand : accModel;
        expB = fonte ? accModel : operand;
        r    = aluRef(1'b0, modo, op, expA, expB);
        e.o  = r[WIDTH-1:0];
        e.c  = r[WIDTH];
        e.z  = (r[WIDTH-1:0] == '0);
        sbQ.push_back(e);
        if (clrHs) accModel = ACC_INIT;
        @(posedge Clk);
        #1;
        Cmd_valid = 1'b0;
        Acc_clr   = clrCap;
        checkOutput("issue_ula_A", {10'b0, ula_A}, {10'b0, expA});
        checkOutput("issue_ula_B", {10'b0, ula_B}, {10'b0, expB});
        checkOutput("issue_ula_Reset", {15'b0, ula_Reset}, 16'd0);
        checkOutput("issue_cmd_ready", {15'b0, Cmd_ready}, 16'd0);
        checkOutput("issue_rsp_valid", {15'b0, Rsp_valid}, 16'd0);
        if (grava) accModel = e.o;
        if (clrCap) accModel = ACC_INIT;
    endtask

    task automatic collectResponse(input int holdCycles);
        rsp_t e;
        @(posedge Clk);
        #1;
        Acc_clr = 1'b0;
        checkOutput("resp_valid_latency", {15'b0, Rsp_valid}, 16'd1);
        checkOutput("resp_ula_Reset", {15'b0, ula_Reset}, 16'd1);
        checkOutput("resp_cmd_ready", {15'b0, Cmd_ready}, 16'd0);
        if (sbQ.size() == 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
            e.o = '0; e.c = 1'b0; e.z = 1'b0;
        end else begin
            e = sbQ.pop_front();
        end
        checkOutput("rsp_O", {10'b0, Rsp_O}, {10'b0, e.o});
        checkOutput("rsp_Carry", {15'b0, Rsp_Carry}, {15'b0, e.c});
        checkOutput("rsp_Zero", {15'b0, Rsp_Zero}, {15'b0, e.z});
        checkOutput("acc_after_capture", {10'b0, Acc}, {10'b0, accModel});
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge Clk);
            #1;
            checkOutput("hold_rsp_valid", {15'b0, Rsp_valid}, 16'd1);
            checkOutput("hold_rsp_O", {10'b0, Rsp_O}, {10'b0, e.o});
            checkOutput("hold_cmd_ready", {15'b0, Cmd_ready}, 16'd0);
        end
        Rsp_ready = 1'b1;
        @(posedge Clk);
        #1;
        Rsp_ready = 1'b0;
        checkOutput("after_hs_rsp_valid", {15'b0, Rsp_valid}, 16'd0);
        checkOutput("after_hs_cmd_ready", {15'b0, Cmd_ready}, 16'd1);
    endtask

    initial begin
        Reset_n      = 1'b0;
        Cmd_valid    = 1'b0;
        Cmd_Modo     = 1'b0;
        Cmd_Operacao = 3'b000;
        Cmd_Operando = '0;
        Cmd_Fonte    = 1'b0;
        Cmd_Grava    = 1'b0;
        Acc_clr      = 1'b0;
        Rsp_ready    = 1'b0;
        accModel     = ACC_INIT;

        #12;
        checkOutput("reset_cmd_ready", {15'b0, Cmd_ready}, 16'd0);
        checkOutput("reset_rsp_valid", {15'b0, Rsp_valid}, 16'd0);
        checkOutput("reset_ula_Reset", {15'b0, ula_Reset}, 16'd1);
        checkOutput("reset_acc", {10'b0, Acc}, {10'b0, ACC_INIT});
        checkOutput("reset_ula_A", {10'b0, ula_A}, 16'd0);
        checkOutput("reset_rsp_O", {10'b0, Rsp_O}, 16'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        $display("[TB] load 5 into ACC");
        applyStimulus(1'b0, 3'b000, 6'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        collectResponse(0);

        $display("[TB] add 60 with wrap");
        applyStimulus(1'b0, 3'b000, 6'd60, 1'b0, 1'b1, 1'b0, 1'b0);
        collectResponse(0);
        checkOutput("wrap_carry_const", {15'b0, Rsp_Carry}, 16'd1);
        checkOutput("wrap_acc_const", {10'b0, Acc}, 16'd1);
`ifdef ULA_SEQ_STATS_EN
        checkOutput("stats_op_count", Op_count, 16'd2);
        checkOutput("stats_carry_count", Carry_count, 16'd1);
`endif

        $display("[TB] restore ACC to 5, then A-B giving zero");
        applyStimulus(1'b0, 3'b000, 6'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        collectResponse(0);
        applyStimulus(1'b0, 3'b001, 6'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        collectResponse(0);
        checkOutput("sub_zero_const", {15'b0, Rsp_Zero}, 16'd1);
        checkOutput("sub_acc_kept", {10'b0, Acc}, 16'd5);

        $display("[TB] NOT A with Fonte=1 and response back-pressure");
        applyStimulus(1'b1, 3'b001, 6'b101010, 1'b1, 1'b0, 1'b0, 1'b0);
        collectResponse(3);
        checkOutput("not_result_const", {10'b0, Rsp_O}, 16'b010101);

        $display("[TB] Acc_clr on capture edge");
        applyStimulus(1'b0, 3'b000, 6'd7, 1'b0, 1'b1, 1'b0, 1'b1);
        collectResponse(0);
        checkOutput("clr_cap_rsp_const", {10'b0, Rsp_O}, 16'd12);

        $display("[TB] Acc_clr on handshake edge uses pre-clear ACC");
        applyStimulus(1'b0, 3'b000, 6'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        collectResponse(0);
        applyStimulus(1'b0, 3'b000, 6'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        collectResponse(0);

        $display("[TB] reset during RESP");
        applyStimulus(1'b0, 3'b000, 6'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge Clk);
        #1;
        checkOutput("pre_reset_rsp_valid", {15'b0, Rsp_valid}, 16'd1);
        Reset_n = 1'b0;
        #1;
        sbQ.delete();
        accModel = ACC_INIT;
        checkOutput("midreset_rsp_valid", {15'b0, Rsp_valid}, 16'd0);
        checkOutput("midreset_acc", {10'b0, Acc}, {10'b0, ACC_INIT});
        checkOutput("midreset_ula_Reset", {15'b0, ula_Reset}, 16'd1);
        checkOutput("midreset_cmd_ready", {15'b0, Cmd_ready}, 16'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            checkOutput("post_reset_no_stale", {15'b0, Rsp_valid}, 16'd0);
            checkOutput("post_reset_cmd_ready", {15'b0, Cmd_ready}, 16'd1);
        end

        $display("[TB] command after reset recovery");
        applyStimulus(1'b0, 3'b000, 6'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        collectResponse(1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
